// File: rtl/count_disp_pkg.sv
// Shared definitions for the count display tile: converter FSM states,
// seven-segment code table and one-hot digit enables.
package count_disp_pkg;

    localparam int DIG_W  = 4;
    localparam int N_DIGS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Segment codes for 0..F, bit0 = a ... bit6 = g, active high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [2:0] DIG_EN_UNITS = 3'b001;
    localparam logic [2:0] DIG_EN_TENS  = 3'b010;
    localparam logic [2:0] DIG_EN_HUNDS = 3'b100;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit converter. Decimal mode runs
// shift-and-add-3; hex mode shifts only, leaving the raw nibbles.
// One conversion takes IDLE + 8 CONVERT + COMMIT = 10 cycles.
module bin2bcd_seq
    import count_disp_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [7:0]                i_bin,
    input  logic                      i_hex,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [N_DIGS*DIG_W-1:0]   o_digits,
    output logic                      o_hex
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [7:0]                r_bin;
    logic [N_DIGS*DIG_W-1:0]   r_bcd;
    logic [N_DIGS*DIG_W-1:0]   w_adj;
    logic [2:0]                r_iter;
    logic                      r_hex_work;
    logic [N_DIGS*DIG_W-1:0]   r_digits;
    logic                      r_hex_disp;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: start only from IDLE, fixed 8 convert cycles.
    // NOTE: the default assignment first keeps this purely combinational;
    // a path that leaves w_state_next unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_CONVERT;
            ST_CONVERT: if (r_iter == 3'd7) w_state_next = ST_COMMIT;
            ST_COMMIT:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_busy = (r_state != ST_IDLE);
        o_done = (r_state == ST_COMMIT);
    end

    // Add-3 correction on every BCD nibble >= 5 (skipped in hex mode).
    always_comb begin
        w_adj = r_bcd;
        if (!r_hex_work) begin
            for (int i = 0; i < N_DIGS; i++) begin
                if (r_bcd[i*DIG_W +: DIG_W] >= 4'd5)
                    w_adj[i*DIG_W +: DIG_W] = r_bcd[i*DIG_W +: DIG_W] + 4'd3;
            end
        end
    end

    // Datapath: latch on start, shift {bcd, bin} in CONVERT, publish in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_hex_work <= 1'b0;
            r_digits   <= '0;
            r_hex_disp <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin      <= i_bin;
                        r_hex_work <= i_hex;
                        r_bcd      <= '0;
                        r_iter     <= '0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd  <= {w_adj[N_DIGS*DIG_W-2:0], r_bin[7]};
                    r_bin  <= {r_bin[6:0], 1'b0};
                    r_iter <= r_iter + 3'd1;
                end
                ST_COMMIT: begin
                    r_digits   <= r_hex_work ? {4'h0, r_bcd[2*DIG_W-1:0]} : r_bcd;
                    r_hex_disp <= r_hex_work;
                end
                default: ;
            endcase
        end
    end

    assign o_digits = r_digits;
    assign o_hex    = r_hex_disp;

endmodule

// File: rtl/tt_um_count_display_shivam.sv
// Count display tile: runs the converter continuously on ui_in and scans
// the three committed digits onto a multiplexed common-cathode display.
module tt_um_count_display_shivam
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic                     w_hold;
    logic                     w_hex_sel;
    logic                     w_blank_en;
    logic                     w_start;
    logic                     w_busy;
    logic                     w_done;
    logic [N_DIGS*DIG_W-1:0]  w_digits;
    logic                     w_hex_disp;
    logic                     w_unused;

    logic [PRE_W-1:0]         r_presc;
    logic [1:0]               r_dig_idx;
    logic [6:0]               r_seg;
    logic                     r_dp;
    logic [2:0]               r_en;

    logic                     w_wrap;
    logic [1:0]               w_idx_next;
    logic [DIG_W-1:0]         w_dig;
    logic                     w_blank;
    logic [2:0]               w_en_next;

    assign w_hold     = uio_in[0];
    assign w_hex_sel  = uio_in[1];
    assign w_blank_en = uio_in[2];
    assign w_start    = ena & ~w_hold & ~w_busy;
    assign w_unused   = ^{w_done, uio_in[7:3]};

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_bin    (ui_in),
        .i_hex    (w_hex_sel),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_digits (w_digits),
        .o_hex    (w_hex_disp)
    );

    // Pick the digit for the upcoming slot and decide whether it is blanked.
    always_comb begin
        w_wrap     = (r_presc == PRE_W'(REFRESH_DIV - 1));
        w_idx_next = (r_dig_idx == 2'd2) ? 2'd0 : r_dig_idx + 2'd1;
        w_dig      = w_digits[DIG_W-1:0];
        w_blank    = 1'b0;
        w_en_next  = DIG_EN_UNITS;
        case (w_idx_next)
            2'd1: begin
                w_dig     = w_digits[2*DIG_W-1:DIG_W];
                w_en_next = DIG_EN_TENS;
                w_blank   = !w_hex_disp && w_blank_en &&
                            (w_digits[3*DIG_W-1:2*DIG_W] == 4'd0) &&
                            (w_digits[2*DIG_W-1:DIG_W] == 4'd0);
            end
            2'd2: begin
                w_dig     = w_digits[3*DIG_W-1:2*DIG_W];
                w_en_next = DIG_EN_HUNDS;
                w_blank   = w_hex_disp ||
                            (w_blank_en && (w_digits[3*DIG_W-1:2*DIG_W] == 4'd0));
            end
            default: ;
        endcase
    end

    // Prescaler and registered scan outputs; outputs move only on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_dig_idx <= 2'd0;
            r_seg     <= 7'h00;
            r_dp      <= 1'b0;
            r_en      <= 3'b000;
        end else if (w_wrap) begin
            r_presc   <= '0;
            r_dig_idx <= w_idx_next;
            r_seg     <= w_blank ? 7'h00 : SEG_TABLE[w_dig];
            r_dp      <= w_hex_disp && (w_idx_next == 2'd0);
            r_en      <= w_en_next;
        end else begin
            r_presc   <= r_presc + PRE_W'(1);
        end
    end

    assign uo_out  = {r_dp, r_seg};
    assign uio_out = {5'b00000, r_en};
    assign uio_oe  = 8'b0000_0111;

endmodule
